// File: rtl/uart_sum_tx.sv
// uart_sum_tx: serialises a 4-bit adder sum plus carry-out as one 8N1 UART frame.
// The byte sent is {3'b000, cout_i, sum_i}, LSB first.
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit between
// the data bits and the stop bit, giving an 8E1 frame.
module uart_sum_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] sum_i,
  input  logic       cout_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       byte_q, byte_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state, bit timing and byte latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    done_d  = 1'b0;

    if (state_q == S_IDLE) begin
      if (valid_i) begin
        byte_d  = {3'b000, cout_i, sum_i};
        state_d = S_START;
        cnt_d   = '0;
        bit_d   = '0;
      end
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      case (state_q)
        S_START: begin
          state_d = S_DATA;
          bit_d   = '0;
        end
        S_DATA: begin
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: state_d = S_STOP;
`endif
        S_STOP: begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Line level and handshake flags decoded from the next state so they register cleanly.
  always_comb begin
    tx_d    = 1'b1;
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = byte_d[bit_d];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = ^byte_d;
`endif
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  // State and output registers; reset wins over any pending request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx_o    = tx_q;
  assign ready_o = ready_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_uart_sum_tx.sv
// Bench for uart_sum_tx with CLKS_PER_BIT=4: a frame-position model checked every cycle,
// plus literal per-bit patterns for each directed frame.
module tb_uart_sum_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic [3:0] sum_i = 4'h0;
  logic       cout_i = 1'b0;
  logic       valid_i = 1'b0;
  logic       ready_o, tx_o, busy_o, done_o;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  uart_sum_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .sum_i  (sum_i),
    .cout_i (cout_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .tx_o   (tx_o),
    .busy_o (busy_o),
    .done_o (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is just a byte plus a cycle position inside a fixed-length frame.
  bit       m_active = 1'b0;
  int       m_pos = 0;
  logic [7:0] m_byte = 8'h00;
  bit       m_done = 1'b0;

  always @(posedge clk) begin
    if (rst_i) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_pos    <= 0;
    end else if (!m_active && valid_i) begin
      m_active <= 1'b1;
      m_pos    <= 0;
      m_byte   <= {3'b000, cout_i, sum_i};
      m_done   <= 1'b0;
    end else if (m_active) begin
      if (m_pos == FRAME - 1) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
      end else begin
        m_pos  <= m_pos + 1;
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  function automatic logic exp_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_pos / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^m_byte;
`endif
    return 1'b1;
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_tx", 32'(tx_o), 32'(exp_tx()));
      chk("model_ready", 32'(ready_o), 32'(!m_active));
      chk("model_busy", 32'(busy_o), 32'(m_active));
      chk("model_done", 32'(done_o), 32'(m_done));
    end
  end

  // Starts at the negedge of frame cycle 1; checks each bit against a literal pattern
  // and the done pulse in cycle FRAME+1; returns at the negedge of the done cycle.
  task automatic watch_frame(input string name, input logic [0:10] pat);
    logic [0:10] p;
    p = pat;
    for (int c = 1; c <= FRAME + 1; c++) begin
      if (c > 1) @(negedge clk);
      if (c <= FRAME) begin
        chk({name, "_tx"}, 32'(tx_o), 32'(p[(c-1)/CPB]));
        if (c == 1 || c == FRAME) chk({name, "_busy"}, 32'(busy_o), 32'd1);
      end else begin
        chk({name, "_done"}, 32'(done_o), 32'd1);
        chk({name, "_ready"}, 32'(ready_o), 32'd1);
        chk({name, "_tx_idle"}, 32'(tx_o), 32'd1);
      end
    end
  endtask

  // Presents a request for one edge; leaves valid high when hold is set.
  task automatic send(input logic [3:0] s, input logic c, input bit hold);
    @(negedge clk);
    sum_i = s; cout_i = c; valid_i = 1'b1;
    @(negedge clk);
    if (!hold) valid_i = 1'b0;
  endtask

`ifdef UART_TX_PARITY_EN
  localparam logic [0:10] PAT_1A = 11'b00101100011;
  localparam logic [0:10] PAT_1F = 11'b01111100011;
  localparam logic [0:10] PAT_00 = 11'b00000000001;
  localparam logic [0:10] PAT_05 = 11'b01010000001;
`else
  localparam logic [0:10] PAT_1A = 11'b00101100010;
  localparam logic [0:10] PAT_1F = 11'b01111100010;
  localparam logic [0:10] PAT_00 = 11'b00000000010;
  localparam logic [0:10] PAT_05 = 11'b01010000010;
`endif

  initial begin
    // Reset and idle.
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    chk("rst_tx", 32'(tx_o), 32'd1);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk_en = 1'b1;
    repeat (20) @(negedge clk);

    // Single frame 0x1A.
    send(4'hA, 1'b1, 1'b0);
    watch_frame("f1a", PAT_1A);
    repeat (3) @(negedge clk);

    // Back-to-back with valid held: 0x1F then 0x00, no idle gap.
    send(4'hF, 1'b1, 1'b1);
    sum_i = 4'h0; cout_i = 1'b0;
    watch_frame("b2b_1f", PAT_1F);
    @(negedge clk);
    valid_i = 1'b0;
    watch_frame("b2b_00", PAT_00);
    repeat (3) @(negedge clk);

    // Request during DATA is ignored.
    send(4'h5, 1'b0, 1'b0);
    fork
      watch_frame("ign_05", PAT_05);
      begin
        repeat (10) @(negedge clk);
        sum_i = 4'hF; cout_i = 1'b1; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
      end
    join
    repeat (3) @(negedge clk);

    // Reset during data bit 3 aborts without done.
    send(4'hA, 1'b1, 1'b0);
    repeat (17) @(negedge clk);
    chk("pre_rst_busy", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("abort_tx", 32'(tx_o), 32'd1);
    chk("abort_ready", 32'(ready_o), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("abort_no_done", 32'(done_o), 32'd0);
      @(negedge clk);
    end
    send(4'hA, 1'b1, 1'b0);
    watch_frame("post_rst_1a", PAT_1A);
    repeat (2) @(negedge clk);

    // Reset and request on the same edge: request dropped.
    sum_i = 4'h3; cout_i = 1'b0; valid_i = 1'b1; rst_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; rst_i = 1'b0;
    chk("rst_prio_ready", 32'(ready_o), 32'd1);
    chk("rst_prio_tx", 32'(tx_o), 32'd1);
    repeat (6) @(negedge clk);
    chk("rst_prio_idle", 32'(busy_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
